// File: rtl/serial_mag_cmp_pkg.sv
// Shared types for the digit-serial magnitude comparator: FSM state encoding,
// one-hot verdict constants and the MSB-first verdict merge rule.
package serial_mag_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One-hot {gt, eq, lt}; all-zero only exists as the post-reset output value.
    typedef logic [2:0] verdict_t;

    localparam verdict_t VERDICT_GT   = 3'b100;
    localparam verdict_t VERDICT_EQ   = 3'b010;
    localparam verdict_t VERDICT_LT   = 3'b001;
    localparam verdict_t VERDICT_NONE = 3'b000;

    // The first unequal digit (MSB first) decides; later digits only matter while still equal.
    function automatic verdict_t merge_verdict(input verdict_t running, input verdict_t digit);
        return (running == VERDICT_EQ) ? digit : running;
    endfunction

endpackage

// File: rtl/serial_mag_cmp_if.sv
// Handshake and result bundle between a digit source (master) and the comparator (slave).
interface serial_mag_cmp_if;

    logic       start;
    logic       digitValid;
    logic [1:0] inA;
    logic [1:0] inB;
    logic       busy;
    logic       done;
    logic       outGT;
    logic       outEQ;
    logic       outLT;

    modport master (
        output start, digitValid, inA, inB,
        input  busy, done, outGT, outEQ, outLT
    );

    modport slave (
        input  start, digitValid, inA, inB,
        output busy, done, outGT, outEQ, outLT
    );

endinterface

// File: rtl/serial_mag_cmp_digit_cmp2.sv
// Combinational compare of one 2-bit digit pair, producing a one-hot GT/EQ/LT verdict.
module digit_cmp2
    import serial_mag_cmp_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    output verdict_t   res
);

    always_comb begin
        if (a > b) begin
            res = VERDICT_GT;
        end else if (a < b) begin
            res = VERDICT_LT;
        end else begin
            res = VERDICT_EQ;
        end
    end

endmodule

// File: rtl/serial_mag_cmp.sv
// Digit-serial magnitude comparator: consumes NUM_DIGITS 2-bit digit pairs MSB first
// and registers one GT/EQ/LT verdict per operand pair, flagged by a one-cycle done.
module serial_mag_cmp
    import serial_mag_cmp_pkg::*;
#(
    parameter int NUM_DIGITS = 4
)
(
    input  logic             clk,
    input  logic             reset,
    serial_mag_cmp_if.slave  bus
);

    localparam int CNT_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    verdict_t         run_q, run_d;
    verdict_t         out_q, out_d;
    verdict_t         digit_res;
    verdict_t         merged;

    digit_cmp2 u_digit_cmp2 (
        .a   (bus.inA),
        .b   (bus.inB),
        .res (digit_res)
    );

    assign merged = merge_verdict(run_q, digit_res);

    // NOTE: every signal assigned in this block gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        out_d   = out_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    run_d   = VERDICT_EQ;
                end
            end

            ST_SCAN: begin
                // Gap cycles (digitValid low) leave everything untouched.
                if (bus.digitValid) begin
                    run_d = merged;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_DIGIT) begin
                        state_d = ST_DONE;
                        out_d   = merged;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            run_q   <= VERDICT_EQ;
            out_q   <= VERDICT_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            out_q   <= out_d;
        end
    end

    // Status decodes straight from the state register, so they are glitch-free.
    assign bus.busy  = (state_q == ST_SCAN);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.outGT = out_q[2];
    assign bus.outEQ = out_q[1];
    assign bus.outLT = out_q[0];

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Directed bench for serial_mag_cmp (NUM_DIGITS=4): stimulus pushes expected verdicts
// into a scoreboard queue and a separate monitor pops and compares on every done.
module tb_serial_mag_cmp;
    import serial_mag_cmp_pkg::*;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    verdict_t sb[$];

    serial_mag_cmp_if bus ();

    serial_mag_cmp #(.NUM_DIGITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic verdict_t outs();
        return {bus.outGT, bus.outEQ, bus.outLT};
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
            end else begin
                check("verdict", 32'(outs()), 32'(sb.pop_front()));
            end
        end
    end

    // Full comparison: gap = idle cycles between beats, poke = hold start high through SCAN and DONE.
    task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input int gap,
                           input bit poke, input verdict_t exp);
        sb.push_back(exp);
        @(posedge clk) #1;
        bus.start = 1'b1;
        @(posedge clk) #1;
        if (!poke) bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.digitValid = 1'b1;
            bus.inA = a[7-2*i -: 2];
            bus.inB = b[7-2*i -: 2];
            @(negedge clk);
            check("busy_scan", 32'(bus.busy), 32'd1);
            @(posedge clk) #1;
            bus.digitValid = 1'b0;
            bus.inA = ~a[7-2*i -: 2];
            bus.inB = ~b[7-2*i -: 2];
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check("gap_no_done", 32'(bus.done), 32'd0);
                    @(posedge clk) #1;
                end
            end
        end
        @(negedge clk);
        check("done_latency", 32'(bus.done), 32'd1);
        check("busy_in_done", 32'(bus.busy), 32'd0);
        @(posedge clk) #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_after_done", 32'({bus.busy, bus.done}), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.digitValid = 1'b0;
        bus.inA        = 2'b00;
        bus.inB        = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_outs", 32'(outs()), 32'd0);
        @(posedge clk) #1;
        reset = 1'b0;

        // GT decided at third digit: B4 vs B1, exact cycle-by-cycle timing.
        sb.push_back(VERDICT_GT);
        @(posedge clk) #1;
        bus.start = 1'b1;
        @(posedge clk) #1;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] a_op;
            logic [7:0] b_op;
            a_op = 8'hB4;
            b_op = 8'hB1;
            bus.digitValid = 1'b1;
            bus.inA = a_op[7-2*i -: 2];
            bus.inB = b_op[7-2*i -: 2];
            @(negedge clk);
            check("t1_busy", 32'(bus.busy), 32'd1);
            check("t1_no_early_done", 32'(bus.done), 32'd0);
            @(posedge clk) #1;
        end
        bus.digitValid = 1'b0;
        @(negedge clk);
        check("t1_done_cycle5", 32'(bus.done), 32'd1);
        check("t1_busy_cycle5", 32'(bus.busy), 32'd0);

        // Equal operands, back-to-back, including all-zero and all-ones.
        run_cmp(8'h5A, 8'h5A, 0, 1'b0, VERDICT_EQ);
        run_cmp(8'h00, 8'h00, 0, 1'b0, VERDICT_EQ);
        run_cmp(8'hFF, 8'hFF, 0, 1'b0, VERDICT_EQ);

        // MSB dominance: later A>B digits must not flip LT.
        run_cmp(8'h3F, 8'h40, 0, 1'b0, VERDICT_LT);

        // Ignored digitValid in IDLE: no start, outputs hold LT.
        @(posedge clk) #1;
        bus.digitValid = 1'b1;
        bus.inA = 2'b11;
        bus.inB = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_valid_busy", 32'(bus.busy), 32'd0);
            @(posedge clk) #1;
        end
        bus.digitValid = 1'b0;
        @(negedge clk);
        check("idle_outs_hold", 32'(outs()), 32'(VERDICT_LT));

        // Gapped beats with garbage on the bus during gaps.
        run_cmp(8'hC0, 8'h80, 2, 1'b0, VERDICT_GT);

        // start held high through SCAN and DONE: no restart, single done.
        run_cmp(8'h12, 8'h21, 0, 1'b1, VERDICT_LT);
        repeat (2) begin
            @(negedge clk);
            check("no_restart", 32'({bus.busy, bus.done}), 32'd0);
        end
        check("outs_hold", 32'(outs()), 32'(VERDICT_LT));

        // Reset after two beats, with a valid third digit on the bus to show reset priority.
        @(posedge clk) #1;
        bus.start = 1'b1;
        @(posedge clk) #1;
        bus.start = 1'b0;
        bus.digitValid = 1'b1;
        bus.inA = 2'b11;
        bus.inB = 2'b00;
        @(posedge clk) #1;
        @(posedge clk) #1;
        reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
        bus.digitValid = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_done", 32'(bus.done), 32'd0);
        check("rst_mid_outs", 32'(outs()), 32'd0);
        run_cmp(8'h01, 8'h02, 0, 1'b0, VERDICT_LT);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
